// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the data-memory access stage:
//   - state_e      : access FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   - F3_*         : funct3 encodings for load/store size and sign
//   - helpers      : alignment check and store lane/strobe generation, driven
//                    by the two size bits of funct3 (00 byte, 01 half, 1x word)
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always fine.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    if (size[1])      mis = (addr_lo != 2'b00);
    else if (size[0]) mis = addr_lo[0];
    else              mis = 1'b0;
    return mis;
  endfunction

  // Byte-lane write strobe for an aligned store.
  function automatic logic [3:0] store_strb(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] strb;
    if (size[1])      strb = 4'b1111;
    else if (size[0]) strb = addr_lo[1] ? 4'b1100 : 4'b0011;
    else              strb = 4'b0001 << addr_lo;
    return strb;
  endfunction

  // Store data replicated across every lane so the strobe alone selects it.
  function automatic logic [31:0] store_data(input logic [1:0] size,
                                             input logic [31:0] wdata);
    logic [31:0] d;
    if (size[1])      d = wdata;
    else if (size[0]) d = {2{wdata[15:0]}};
    else              d = {4{wdata[7:0]}};
    return d;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Picks the addressed byte/halfword out of a 32-bit memory word and sign- or
// zero-extends it according to funct3. Purely combinational.
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU)
//   addr_lo in  2   byte offset within the word
//   rdata   in  32  raw word from data memory
//   data    out 32  extended load result
// -----------------------------------------------------------------------------
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;  // LW / FLW
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage controller between the EX/MEM register and a ready/ack data memory.
// Aligned loads/stores stall the front of the pipeline while the request is
// outstanding; non-memory instructions pass straight through to MEM/WB.
// Ports:
//   clk, rst (active-low, asynchronous)
//   ex_*   : EX/MEM register contents (valid, memread/memwrite, funct3, addr,
//            wdata, rd, regwrite, floatwb)
//   dm_*   : data-memory request (req, we, wstrb, word addr, wdata) and
//            response (ack, rdata)
//   stall  : freezes PC/IF/ID/EX and EX/MEM
//   wb_*   : values for the MEM/WB register
//   misalign : one-cycle indication of a misaligned access (no request made)
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_floatwb,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [31:0] wb_alu,
  output logic        wb_memtoreg,
  output logic        wb_regwrite,
  output logic        wb_floatwb,
  output logic [4:0]  wb_rd,
  output logic        misalign
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        memread_q, memread_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] alu_q, alu_d;        // full byte address; also the wb_alu value
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        floatwb_q, floatwb_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        mem_op;
  logic        mis_c;
  logic        misalign_c;
  logic [31:0] load_data;

  load_extend u_load_extend (
    .funct3  (funct3_q),
    .addr_lo (alu_q[1:0]),
    .rdata   (dm_rdata),
    .data    (load_data)
  );

  assign mem_op = ex_valid & (ex_memread | ex_memwrite);
  assign mis_c  = is_misaligned(ex_funct3[1:0], ex_addr[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      memread_q  <= 1'b0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
      alu_q      <= 32'd0;
      funct3_q   <= 3'd0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      floatwb_q  <= 1'b0;
      wb_data_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      memread_q  <= memread_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      alu_q      <= alu_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      floatwb_q  <= floatwb_d;
      wb_data_q  <= wb_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    memread_d   = memread_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    alu_d       = alu_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    regwrite_d  = regwrite_q;
    floatwb_d   = floatwb_q;
    wb_data_d   = wb_data_q;
    stall       = 1'b0;
    dm_req      = 1'b0;
    misalign_c  = 1'b0;
    wb_alu      = alu_q;
    wb_rd       = rd_q;
    wb_memtoreg = 1'b0;
    wb_regwrite = 1'b0;
    wb_floatwb  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wb_alu = ex_addr;
        wb_rd  = ex_rd;
        if (mem_op) begin
          if (mis_c) begin
            // Dropped access: nothing reaches memory, nothing is written back.
            misalign_c = 1'b1;
          end else begin
            stall      = 1'b1;
            we_d       = ex_memwrite;
            memread_d  = ex_memread;
            wstrb_d    = store_strb(ex_funct3[1:0], ex_addr[1:0]);
            wdata_d    = store_data(ex_funct3[1:0], ex_wdata);
            alu_d      = ex_addr;
            funct3_d   = ex_funct3;
            rd_d       = ex_rd;
            regwrite_d = ex_regwrite;
            floatwb_d  = ex_floatwb;
            state_d    = ST_BUSY;
          end
        end else begin
          wb_regwrite = ex_regwrite & ex_valid;
          wb_floatwb  = ex_floatwb & ex_valid;
        end
      end

      ST_BUSY: begin
        stall  = 1'b1;
        dm_req = 1'b1;
        if (dm_ack) begin
          // Stores keep the previous wb_data; only loads capture a result.
          if (memread_q) wb_data_d = load_data;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Stores never write back, regardless of the regwrite bit they carried.
        wb_memtoreg = memread_q;
        wb_regwrite = regwrite_q & memread_q;
        wb_floatwb  = floatwb_q & memread_q;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Request attributes only qualify while the request is live.
  assign dm_we    = (state_q == ST_BUSY) & we_q;
  assign dm_wstrb = (state_q == ST_BUSY) ? wstrb_q : 4'd0;
  assign dm_addr  = {alu_q[31:2], 2'b00};
  assign dm_wdata = wdata_q;
  assign wb_data  = wb_data_q;
  // Misalign is decoded from live EX inputs, so reset must mask it directly.
  assign misalign = misalign_c & rst;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_floatwb;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall;
  logic [31:0] wb_data;
  logic [31:0] wb_alu;
  logic        wb_memtoreg;
  logic        wb_regwrite;
  logic        wb_floatwb;
  logic [4:0]  wb_rd;
  logic        misalign;

  int checks;
  int failures;
  logic [31:0] model_wb_data;

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_rd       (ex_rd),
    .ex_regwrite (ex_regwrite),
    .ex_floatwb  (ex_floatwb),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_wstrb    (dm_wstrb),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .stall       (stall),
    .wb_data     (wb_data),
    .wb_alu      (wb_alu),
    .wb_memtoreg (wb_memtoreg),
    .wb_regwrite (wb_regwrite),
    .wb_floatwb  (wb_floatwb),
    .wb_rd       (wb_rd),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from funct3.
  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1]) return 4;
    if (f3[0]) return 2;
    return 1;
  endfunction

  // Expected strobe: the sz consecutive lanes starting at the byte offset.
  function automatic logic [3:0] ref_strb(input int sz, input int lo);
    logic [3:0] s;
    s = 4'd0;
    for (int b = 0; b < 4; b++) if (b >= lo && b < lo + sz) s[b] = 1'b1;
    return s;
  endfunction

  // Expected bus data: lane b carries byte (b mod sz) of the store value.
  function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] v);
    logic [31:0] d;
    for (int b = 0; b < 4; b++) d[8*b +: 8] = v[8*(b % sz) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lo,
                                           input logic [31:0] rdata);
    logic [31:0] t;
    int sz;
    sz = acc_size(f3);
    t = rdata >> (8 * lo);
    if (sz == 1) begin
      t = t & 32'h0000_00FF;
      if (!f3[2] && t[7]) t = t | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      t = t & 32'h0000_FFFF;
      if (!f3[2] && t[15]) t = t | 32'hFFFF_0000;
    end
    return t;
  endfunction

  // One memory instruction from EX/MEM entry through DONE (or the misalign cycle).
  task automatic do_mem(input string name, input logic is_load, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int delay,
                        input logic [4:0] rd, input logic regw, input logic fw);
    int sz, lo, stall_cnt, busy_cnt;
    logic done;
    logic [31:0] exp_load;
    sz = acc_size(f3);
    lo = int'(addr[1:0]);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_memread = is_load; ex_memwrite = !is_load;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    ex_regwrite = regw; ex_floatwb = fw;
    if ((lo % sz) != 0) begin
      @(negedge clk);
      check({name, " misalign"}, {31'd0, misalign}, 32'd1);
      check({name, " mis_stall"}, {31'd0, stall}, 32'd0);
      check({name, " mis_req"}, {31'd0, dm_req}, 32'd0);
      check({name, " mis_regwrite"}, {31'd0, wb_regwrite}, 32'd0);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      check({name, " mis_pulse_end"}, {31'd0, misalign}, 32'd0);
      check({name, " mis_req_after"}, {31'd0, dm_req}, 32'd0);
      $display("TXN %s f3=%0d addr=0x%08h misaligned", name, f3, addr);
      return;
    end
    stall_cnt = 0; busy_cnt = 0; done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!stall) begin done = 1'b1; break; end
      stall_cnt++;
      if (dm_req) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          check({name, " dm_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
          check({name, " dm_we"}, {31'd0, dm_we}, {31'd0, !is_load});
          if (!is_load) begin
            check({name, " dm_wstrb"}, {28'd0, dm_wstrb}, {28'd0, ref_strb(sz, lo)});
            check({name, " dm_wdata"}, dm_wdata, ref_wdata(sz, wd));
          end
        end
        if (busy_cnt == delay + 1) begin
          dm_ack = 1'b1; dm_rdata = rdata;
        end
      end
      @(posedge clk); #1;
      dm_ack = 1'b0; dm_rdata = $urandom;
    end
    check({name, " completed"}, {31'd0, done}, 32'd1);
    check({name, " stall_cycles"}, stall_cnt, delay + 2);
    if (is_load) begin
      exp_load = ref_load(f3, lo, rdata);
      model_wb_data = exp_load;
    end
    check({name, " wb_data"}, wb_data, model_wb_data);
    check({name, " wb_regwrite"}, {31'd0, wb_regwrite}, {31'd0, is_load & regw});
    check({name, " wb_memtoreg"}, {31'd0, wb_memtoreg}, {31'd0, is_load});
    check({name, " wb_floatwb"}, {31'd0, wb_floatwb}, {31'd0, is_load & fw});
    check({name, " wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check({name, " wb_alu"}, wb_alu, addr);
    $display("TXN %s %s f3=%0d addr=0x%08h delay=%0d stall=%0d wb_data=0x%08h",
             name, is_load ? "LOAD" : "STORE", f3, addr, delay, stall_cnt, wb_data);
  endtask

  task automatic do_alu(input string name, input logic [31:0] res, input logic [4:0] rd,
                        input logic regw, input logic valid);
    @(posedge clk); #1;
    ex_valid = valid; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_addr = res; ex_rd = rd; ex_regwrite = regw; ex_floatwb = 1'b0;
    @(negedge clk);
    check({name, " wb_alu"}, wb_alu, res);
    check({name, " wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check({name, " wb_regwrite"}, {31'd0, wb_regwrite}, {31'd0, regw & valid});
    check({name, " stall"}, {31'd0, stall}, 32'd0);
    check({name, " wb_memtoreg"}, {31'd0, wb_memtoreg}, 32'd0);
    $display("TXN %s alu=0x%08h rd=%0d regwrite=%0d valid=%0d", name, res, rd, regw, valid);
  endtask

  initial begin
    logic [2:0] load_f3 [5];
    logic [2:0] f3;
    logic [31:0] a;
    logic ld;
    checks = 0; failures = 0; model_wb_data = 32'd0;
    load_f3[0] = 3'b000; load_f3[1] = 3'b001; load_f3[2] = 3'b010;
    load_f3[3] = 3'b100; load_f3[4] = 3'b101;
    rst = 1'b0; ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
    ex_regwrite = 1'b0; ex_floatwb = 1'b0; dm_ack = 1'b0; dm_rdata = 32'd0;

    // Reset state
    @(negedge clk);
    check("rst dm_req", {31'd0, dm_req}, 32'd0);
    check("rst dm_we", {31'd0, dm_we}, 32'd0);
    check("rst dm_wstrb", {28'd0, dm_wstrb}, 32'd0);
    check("rst dm_addr", dm_addr, 32'd0);
    check("rst dm_wdata", dm_wdata, 32'd0);
    check("rst wb_data", wb_data, 32'd0);
    check("rst misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases
    do_mem("sw_deadbeef", 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3, 5'd1, 1'b1, 1'b0);
    do_mem("lb_103", 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 5'd2, 1'b1, 1'b0);
    do_mem("lbu_103", 1'b1, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 5'd3, 1'b1, 1'b0);
    do_mem("sh_102", 1'b0, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 2, 5'd4, 1'b0, 1'b0);
    do_mem("lw_101", 1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 0, 5'd6, 1'b1, 1'b0);
    do_mem("sh_odd", 1'b0, 3'b001, 32'h201, 32'h5555, 32'h0, 0, 5'd6, 1'b1, 1'b0);
    do_mem("flw_fw", 1'b1, 3'b010, 32'h40, 32'h0, 32'h3F80_0000, 0, 5'd9, 1'b1, 1'b1);
    do_alu("add_rd5", 32'd7, 5'd5, 1'b1, 1'b1);
    do_alu("bubble", 32'h1234, 5'd8, 1'b1, 1'b0);

    // Invalid memory op: no request, no writeback
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h300; ex_regwrite = 1'b1;
    @(negedge clk);
    check("inval stall", {31'd0, stall}, 32'd0);
    check("inval misalign", {31'd0, misalign}, 32'd0);
    check("inval wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("inval dm_req", {31'd0, dm_req}, 32'd0);
    $display("TXN invalid_memread no request");

    // Stray ack while idle is ignored
    ex_memread = 1'b0;
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    @(negedge clk);
    check("idle_ack dm_req", {31'd0, dm_req}, 32'd0);
    check("idle_ack wb_data", wb_data, model_wb_data);
    $display("TXN idle_ack ignored");

    // Randomized mix against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_alu($sformatf("rnd_alu%0d", i), $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'b1);
      end else begin
        ld = 1'($urandom_range(0, 1));
        f3 = ld ? load_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~(32'(acc_size(f3)) - 32'd1);
        do_mem($sformatf("rnd_mem%0d", i), ld, f3, a, $urandom, $urandom,
               int'($urandom_range(0, 4)), 5'($urandom_range(0, 31)),
               ld ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    // Reset in BUSY with a coincident ack: request abandoned, data discarded
    do_mem("lb_before_rst", 1'b1, 3'b000, 32'h10, 32'h0, 32'h0000_00FF, 0, 5'd7, 1'b1, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h200; ex_rd = 5'd10; ex_regwrite = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy dm_req", {31'd0, dm_req}, 32'd1);
    dm_ack = 1'b1; dm_rdata = 32'h1357_9BDF; ex_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rstbusy dm_req", {31'd0, dm_req}, 32'd0);
    check("rstbusy wb_data", wb_data, 32'd0);
    check("rstbusy dm_addr", dm_addr, 32'd0);
    check("rstbusy stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    dm_ack = 1'b0; rst = 1'b1; model_wb_data = 32'd0;
    @(negedge clk);
    check("after_rst dm_req", {31'd0, dm_req}, 32'd0);
    check("after_rst wb_data", wb_data, 32'd0);
    $display("TXN reset_in_busy abandoned");

    do_mem("lh_after_rst", 1'b1, 3'b001, 32'h22, 32'h0, 32'h8001_0000, 1, 5'd11, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
